// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade
// ------------------
// Cascade of NUM_SECTIONS second-order IIR sections for the composite
// encoder chroma path. Every section uses the same transposed structure:
//   v    = r1 + x            (feedback node, wraps at STATE_W)
//   r1'  = a1n*v + r2,  r2' = a2n*v
//   y    = b0*v + l1,   l1' = b1*v + l2,  l2' = b2*v
// Feedback coefficients are stored pre-negated, so their terms are added.
// Two runtime-writable coefficient banks exist (0 = NTSC, 1 = PAL). The
// active bank follows the registered pal_mode. Only the inactive bank
// accepts writes.
//
// Handshake: in_valid marks a sample on in for one cycle. There is no
// ready. A stage whose incoming valid is low holds its state and output
// and drops its own valid. out_valid marks exactly those cycles whose
// pipeline slot carries a sample. Latency is NUM_SECTIONS+1 cycles.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    input sample strobe
//   in          signed input sample (DATA_W)
//   pal_mode    active bank select (1 = PAL); a change flushes the filter
//   cfg_we      coefficient write strobe
//   cfg_addr    {bank, section[2:0], coef[2:0]}; coef 0..4 = b0,b1,b2,a1n,a2n
//   cfg_data    signed coefficient (COEF_W)
//   cfg_err     one-cycle pulse after a rejected write
//   out_valid   output strobe
//   out         signed, saturated filtered sample (DATA_W)
module iir_biquad_cascade #(
    parameter int DATA_W       = 8,
    parameter int STATE_W      = 11,
    parameter int COEF_W       = 12,
    parameter int A_FRAC       = 8,
    parameter int B_FRAC       = 8,
    parameter int NUM_SECTIONS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     pal_mode,
    input  logic                     cfg_we,
    input  logic [6:0]               cfg_addr,
    input  logic signed [COEF_W-1:0] cfg_data,
    output logic                     cfg_err,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out
);

    localparam int PROD_W = COEF_W + STATE_W;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (DATA_W - 1)));
    localparam logic signed [COEF_W-1:0] B_ONE   = COEF_W'(1 << B_FRAC);

    // Full-width signed product of a coefficient and a state-width value.
    function automatic logic signed [PROD_W-1:0] mul(
        input logic signed [COEF_W-1:0]  c,
        input logic signed [STATE_W-1:0] v
    );
        logic signed [PROD_W-1:0] ce;
        logic signed [PROD_W-1:0] ve;
        ce = {{STATE_W{c[COEF_W-1]}}, c};
        ve = {{COEF_W{v[STATE_W-1]}}, v};
        return ce * ve;
    endfunction

    // Round half up, then arithmetic shift by n fractional bits.
    function automatic logic signed [PROD_W-1:0] red(
        input logic signed [PROD_W-1:0] p,
        input int                       n
    );
        logic signed [PROD_W-1:0] half;
        logic signed [PROD_W-1:0] sum;
        half = PROD_W'(1) << (n - 1);
        sum  = p + half;
        return sum >>> n;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(
        input logic signed [PROD_W-1:0] y
    );
        logic signed [DATA_W-1:0] r;
        if (y > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (y < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = y[DATA_W-1:0];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Mode register, flush detect, coefficient banks
    // ---------------------------------------------------------------
    logic                     pal_q;
    logic                     flush;
    logic                     cfg_bank;
    logic [2:0]               cfg_sec;
    logic [2:0]               cfg_coef;
    logic                     cfg_ok;
    logic signed [COEF_W-1:0] coef_q [2][NUM_SECTIONS][5];

    assign flush    = (pal_q != pal_mode);
    assign cfg_bank = cfg_addr[6];
    assign cfg_sec  = cfg_addr[5:3];
    assign cfg_coef = cfg_addr[2:0];
    // Judged against pal_q, so a write on the mode-change edge sees the old mode.
    assign cfg_ok   = cfg_we && (cfg_bank != pal_q) && (cfg_coef <= 3'd4)
                      && ({29'd0, cfg_sec} < NUM_SECTIONS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_q   <= 1'b0;
            cfg_err <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NUM_SECTIONS; s++) begin
                    for (int c = 0; c < 5; c++) begin
                        coef_q[b][s][c] <= (c == 0) ? B_ONE : '0;
                    end
                end
            end
        end else begin
            pal_q   <= pal_mode;
            cfg_err <= cfg_we && !cfg_ok;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NUM_SECTIONS; s++) begin
                    for (int c = 0; c < 5; c++) begin
                        if (cfg_ok && (cfg_bank == 1'(b)) && (cfg_sec == 3'(s))
                            && (cfg_coef == 3'(c))) begin
                            coef_q[b][s][c] <= cfg_data;
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Input register
    // ---------------------------------------------------------------
    logic signed [DATA_W-1:0] x_q;
    logic                     x_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            x_valid_q <= 1'b0;
        end else if (flush) begin
            x_valid_q <= 1'b0;
        end else begin
            x_valid_q <= in_valid;
            if (in_valid) begin
                x_q <= in;
            end
        end
    end

    // ---------------------------------------------------------------
    // Sections
    // ---------------------------------------------------------------
    logic signed [DATA_W-1:0] sec_y [NUM_SECTIONS];
    logic                     sec_v [NUM_SECTIONS];

    for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
        logic signed [DATA_W-1:0]  x_s;
        logic                      vin_s;
        logic signed [STATE_W-1:0] r1_q, r2_q, l1_q, l2_q;
        logic signed [STATE_W-1:0] v;
        logic signed [COEF_W-1:0]  b0, b1, b2, a1n, a2n;
        logic signed [PROD_W-1:0]  y_full;
        logic signed [DATA_W-1:0]  y_q;
        logic                      vld_q;

        if (s == 0) begin : g_head
            assign x_s   = x_q;
            assign vin_s = x_valid_q;
        end else begin : g_tail
            assign x_s   = sec_y[s-1];
            assign vin_s = sec_v[s-1];
        end

        assign b0  = coef_q[pal_q][s][0];
        assign b1  = coef_q[pal_q][s][1];
        assign b2  = coef_q[pal_q][s][2];
        assign a1n = coef_q[pal_q][s][3];
        assign a2n = coef_q[pal_q][s][4];

        assign v      = r1_q + $signed({{(STATE_W-DATA_W){x_s[DATA_W-1]}}, x_s});
        assign y_full = red(mul(b0, v), B_FRAC)
                        + $signed({{(PROD_W-STATE_W){l1_q[STATE_W-1]}}, l1_q});

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r1_q  <= '0;
                r2_q  <= '0;
                l1_q  <= '0;
                l2_q  <= '0;
                y_q   <= '0;
                vld_q <= 1'b0;
            end else if (flush) begin
                // Output register is left as is; only state and valid clear.
                r1_q  <= '0;
                r2_q  <= '0;
                l1_q  <= '0;
                l2_q  <= '0;
                vld_q <= 1'b0;
            end else if (vin_s) begin
                r1_q  <= STATE_W'(red(mul(a1n, v), A_FRAC)) + r2_q;
                r2_q  <= STATE_W'(red(mul(a2n, v), A_FRAC));
                l1_q  <= STATE_W'(red(mul(b1, v), B_FRAC)) + l2_q;
                l2_q  <= STATE_W'(red(mul(b2, v), B_FRAC));
                y_q   <= sat(y_full);
                vld_q <= 1'b1;
            end else begin
                vld_q <= 1'b0;
            end
        end

        assign sec_y[s] = y_q;
        assign sec_v[s] = vld_q;
    end

    assign out       = sec_y[NUM_SECTIONS-1];
    assign out_valid = sec_v[NUM_SECTIONS-1];

endmodule
